comb_reverb_mc: RTL and testbench
=================================

COMB_REVERB_MC -- requirements
Module: comb_reverb_mc

Interface
REQ-001 G_CHANNELS, default 2, number of time-interleaved audio channels (1..8).
REQ-002 G_DATA_WIDTH, default 16, signed sample width.
REQ-003 G_DELAY_DEPTH_LOG2, default 10, log2 of per-channel delay-line depth.
REQ-004 G_GAIN_DECIMAL_BITS, fixed 15; all gains are 1.15 unsigned fixed point, so 0x8000 = 1.0.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  synchronous run enable.
REQ-008 bypass  in  1  dry passthrough mode.
REQ-009 delay_len  in  G_DELAY_DEPTH_LOG2  delay in per-channel samples; 0 is treated as 1.
REQ-010 feedback_gain / dry_gain / wet_gain  in  16 each  1.15 unsigned gains.
REQ-011 sat_clear  in  1  clears sat_flag.
REQ-012 sat_flag  out  1  sticky saturation indicator.
REQ-013 din / din_valid / din_ready  in/in/out  G_DATA_WIDTH/1/1  AXI-stream-style sample input, channels interleaved 0..G_CHANNELS-1.
REQ-014 din_chan  out  $clog2(G_CHANNELS) (min 1)  channel index of the next accepted sample.
REQ-015 dout / dout_valid / dout_ready  out/out/in  G_DATA_WIDTH/1/1  processed output stream, same channel order.

Function
REQ-016 The block SHALL implement a per-channel feedback comb: w = sat(x + fb*d), y = sat(dry*x + wet*d), where d = w of the same channel delay_len samples earlier.
REQ-017 The FSM SHALL have the states CLEAR, IDLE, READ, CALC and HOLD.
REQ-018 CLEAR: the block SHALL write zero to all G_CHANNELS*2^G_DELAY_DEPTH_LOG2 words at one word per cycle, then go to IDLE; din_ready SHALL be 0 throughout.
REQ-019 IDLE: din_ready = 1; din_valid & din_ready latches x, delay_len, all gains and bypass, then the FSM goes to READ.
REQ-020 READ: the RAM read address SHALL be {chan, (wr_ptr - delay_len) mod 2^G_DELAY_DEPTH_LOG2}; the FSM then goes to CALC.
REQ-021 CALC: the block SHALL compute y and w, write w to {chan, wr_ptr}, register y to dout, set dout_valid, and go to HOLD.
REQ-022 HOLD: dout and dout_valid SHALL stay stable until dout_ready = 1, then the FSM returns to IDLE in the next cycle.
REQ-023 Latency and throughput: dout_valid SHALL rise 3 cycles after the input handshake; at most 1 sample is in flight; peak throughput is 1 sample per 4 cycles.
REQ-024 The channel counter SHALL advance on every input handshake and wrap from G_CHANNELS-1 to 0; wr_ptr SHALL advance, modulo depth, only when channel G_CHANNELS-1 completes CALC.
REQ-025 Arithmetic: products SHALL be G_DATA_WIDTH+17 bits signed, arithmetic right-shifted by 15 (floor); sums SHALL be full width, then saturated to [-2^(W-1), 2^(W-1)-1].
REQ-026 Any saturation event in w or y SHALL set sat_flag; sat_clear SHALL clear it, and a saturation in the same cycle as sat_clear wins.
REQ-027 A sample latched with bypass = 1 SHALL produce y = x with the same latency; the RAM SHALL NOT be written, but the pointers SHALL advance normally.
REQ-028 Gain, delay_len or bypass changes mid-sample SHALL NOT affect the in-flight sample; they take effect at the next handshake.
REQ-029 enable = 0 SHALL synchronously force the FSM to IDLE with dout_valid = 0 and din_ready = 0 (the in-flight sample is discarded) and reset the channel counter and wr_ptr.
REQ-030 A rising edge of enable SHALL start CLEAR.

Reset
REQ-031 On reset_n = 0, asynchronously: dout = 0, dout_valid = 0, din_ready = 0, sat_flag = 0, channel counter = 0, wr_ptr = 0, and the FSM is in CLEAR with its clear address at 0.
REQ-032 After reset_n deasserts with enable = 1, CLEAR SHALL run to completion before the first din_ready; with enable = 0 it SHALL wait in CLEAR.
REQ-033 Reset asserted mid-operation SHALL abandon any in-flight sample and restart CLEAR.

Verification
REQ-034 Setup G_CHANNELS=2, G_DELAY_DEPTH_LOG2=4, enable=1: release reset -> din_ready = 0 for exactly 32 cycles, then 1.
REQ-035 delay_len=3, fb=0x4000, dry=wet=0x8000; ch0 stream 1000,0,0,... with ch1 all 0 -> ch0 out 1000,0,0,1000,0,0,500,0,0,250; ch1 out all 0.
REQ-036 delay_len=1, fb=0x8000, dry=wet=0x8000; ch0 input 30000,30000 -> ch0 outputs 30000 then 32767, and sat_flag = 1 until a sat_clear pulse.
REQ-037 dout_ready held low for 10 cycles while dout_valid = 1 -> dout is stable and din_ready = 0 throughout; 1 cycle after dout_ready = 1, din_ready = 1.
REQ-038 reset_n pulsed low during CALC -> dout_valid = 0 immediately, and a re-run of the REQ-035 impulse matches the first run exactly.
REQ-039 bypass=1, input -1234 -> output -1234 after 3 cycles; after bypass=0, the REQ-035 impulse shows no contribution from the bypassed sample.

Source files
------------

// File: rtl/comb_reverb_mc.sv
// Multi-channel feedback comb reverb.
// Channels arrive time-interleaved on one stream; each channel owns a slice of
// a shared delay RAM addressed as {channel, pointer}. One sample is processed
// at a time through CLEAR/IDLE/READ/CALC/HOLD. Gains are 1.15 unsigned.
module comb_reverb_mc #(
    parameter int G_CHANNELS         = 2,
    parameter int G_DATA_WIDTH       = 16,
    parameter int G_DELAY_DEPTH_LOG2 = 10
) (
    input  logic                                                   clk,
    input  logic                                                   reset_n,
    input  logic                                                   enable,
    input  logic                                                   bypass,
    input  logic [G_DELAY_DEPTH_LOG2-1:0]                          delay_len,
    input  logic [15:0]                                            feedback_gain,
    input  logic [15:0]                                            dry_gain,
    input  logic [15:0]                                            wet_gain,
    input  logic                                                   sat_clear,
    output logic                                                   sat_flag,
    input  logic signed [G_DATA_WIDTH-1:0]                         din,
    input  logic                                                   din_valid,
    output logic                                                   din_ready,
    output logic [((G_CHANNELS > 1) ? $clog2(G_CHANNELS) : 1)-1:0] din_chan,
    output logic signed [G_DATA_WIDTH-1:0]                         dout,
    output logic                                                   dout_valid,
    input  logic                                                   dout_ready
);

    localparam int G_GAIN_DECIMAL_BITS = 15;
    localparam int W     = G_DATA_WIDTH;
    localparam int DL    = G_DELAY_DEPTH_LOG2;
    localparam int DEPTH = 1 << DL;
    localparam int CH_W  = (G_CHANNELS > 1) ? $clog2(G_CHANNELS) : 1;
    localparam int AW    = CH_W + DL;
    localparam int WORDS = G_CHANNELS * DEPTH;
    localparam int PW    = W + 17;   // gain (17b signed) times sample
    localparam int SW    = W + 18;   // full-width sum of two products

    localparam logic [CH_W-1:0]        LAST_CHAN = CH_W'(G_CHANNELS - 1);
    localparam logic [AW-1:0]          LAST_CLR  = AW'(WORDS - 1);
    localparam logic signed [SW-1:0]   SAT_MAX   = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0]   SAT_MIN   = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_CALC  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // 1.15 gain times sample, floor-shifted back to sample scale, widened for summing
    function automatic logic signed [SW-1:0] mul_q15(input logic [15:0] g,
                                                     input logic signed [W-1:0] v);
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] s;
        p = $signed({1'b0, g}) * v;
        s = p >>> G_GAIN_DECIMAL_BITS;
        return {{(SW-PW){s[PW-1]}}, s};
    endfunction

    // Clamp to the sample range; MSB of the result flags that clamping occurred
    function automatic logic [W:0] sat_w(input logic signed [SW-1:0] v);
        logic [W:0] r;
        if (v > SAT_MAX) begin
            r = {1'b1, SAT_MAX[W-1:0]};
        end else if (v < SAT_MIN) begin
            r = {1'b1, SAT_MIN[W-1:0]};
        end else begin
            r = {1'b0, v[W-1:0]};
        end
        return r;
    endfunction

    state_t                state_r, state_next_s;
    logic [AW-1:0]         clr_addr_r;
    logic [CH_W-1:0]       chan_r, cur_chan_r;
    logic [DL-1:0]         wr_ptr_r, dl_r;
    logic signed [W-1:0]   x_r, rd_data_r, dout_r;
    logic [15:0]           fb_r, dry_r, wet_r;
    logic                  byp_r, enable_d_r, dout_valid_r, din_ready_r, sat_flag_r;

    logic signed [W-1:0]   mem [0:WORDS-1];

    logic                  hs_s, sat_event_s, w_sat_s, y_sat_s, mem_we_s;
    logic signed [SW-1:0]  w_sum_s, y_sum_s;
    logic signed [W-1:0]   w_s, y_s, mem_wdata_s;
    logic [AW-1:0]         rd_addr_s, mem_waddr_s;

    // Arithmetic, handshake detect and RAM port selection
    always_comb begin
        hs_s        = enable && enable_d_r && (state_r == ST_IDLE) && din_valid && din_ready_r;
        w_sum_s     = {{(SW-W){x_r[W-1]}}, x_r} + mul_q15(fb_r, rd_data_r);
        y_sum_s     = mul_q15(dry_r, x_r) + mul_q15(wet_r, rd_data_r);
        {w_sat_s, w_s} = sat_w(w_sum_s);
        {y_sat_s, y_s} = sat_w(y_sum_s);
        sat_event_s = enable && (state_r == ST_CALC) && !byp_r && (w_sat_s || y_sat_s);
        rd_addr_s   = {cur_chan_r, wr_ptr_r - dl_r};
        if (state_r == ST_CLEAR) begin
            mem_we_s    = enable;
            mem_waddr_s = clr_addr_r;
            mem_wdata_s = '0;
        end else begin
            mem_we_s    = enable && (state_r == ST_CALC) && !byp_r;
            mem_waddr_s = {cur_chan_r, wr_ptr_r};
            mem_wdata_s = w_s;
        end
    end

    // Next-state logic: enable low parks in IDLE (or holds CLEAR), enable rise restarts CLEAR
    always_comb begin
        state_next_s = state_r;
        if (!enable) begin
            if (state_r == ST_CLEAR) begin
                state_next_s = ST_CLEAR;
            end else begin
                state_next_s = ST_IDLE;
            end
        end else if (!enable_d_r && (state_r != ST_CLEAR)) begin
            state_next_s = ST_CLEAR;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_addr_r == LAST_CLR) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_CLEAR;
                    end
                end
                ST_IDLE: begin
                    if (hs_s) begin
                        state_next_s = ST_READ;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_READ: state_next_s = ST_CALC;
                ST_CALC: state_next_s = ST_HOLD;
                ST_HOLD: begin
                    if (dout_ready) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_HOLD;
                    end
                end
                default: state_next_s = ST_CLEAR;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Control counters, sample latches, registered outputs and sticky saturation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_d_r   <= 1'b1;
            clr_addr_r   <= '0;
            chan_r       <= '0;
            cur_chan_r   <= '0;
            wr_ptr_r     <= '0;
            x_r          <= '0;
            dl_r         <= DL'(1);
            fb_r         <= 16'h0000;
            dry_r        <= 16'h0000;
            wet_r        <= 16'h0000;
            byp_r        <= 1'b0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            din_ready_r  <= 1'b0;
            sat_flag_r   <= 1'b0;
        end else begin
            enable_d_r  <= enable;
            din_ready_r <= enable && (state_next_s == ST_IDLE);

            if ((state_r == ST_CLEAR) && (state_next_s == ST_CLEAR) && enable) begin
                clr_addr_r <= clr_addr_r + AW'(1);
            end else begin
                clr_addr_r <= '0;
            end

            if (!enable) begin
                chan_r <= '0;
            end else if (hs_s) begin
                chan_r <= (chan_r == LAST_CHAN) ? '0 : chan_r + CH_W'(1);
            end

            if (!enable) begin
                wr_ptr_r <= '0;
            end else if ((state_r == ST_CALC) && (cur_chan_r == LAST_CHAN)) begin
                wr_ptr_r <= wr_ptr_r + DL'(1);
            end

            // Everything the sample needs is frozen here so later input changes wait
            if (hs_s) begin
                x_r        <= din;
                dl_r       <= (delay_len == '0) ? DL'(1) : delay_len;
                fb_r       <= feedback_gain;
                dry_r      <= dry_gain;
                wet_r      <= wet_gain;
                byp_r      <= bypass;
                cur_chan_r <= chan_r;
            end

            if (!enable) begin
                dout_valid_r <= 1'b0;
            end else if (state_r == ST_CALC) begin
                dout_r       <= byp_r ? x_r : y_s;
                dout_valid_r <= 1'b1;
            end else if ((state_r == ST_HOLD) && dout_ready) begin
                dout_valid_r <= 1'b0;
            end

            if (sat_event_s) begin
                sat_flag_r <= 1'b1;
            end else if (sat_clear) begin
                sat_flag_r <= 1'b0;
            end
        end
    end

    // Delay RAM: one write port, synchronous read of the tap for the pending sample
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
        rd_data_r <= mem[rd_addr_s];
    end

    assign din_ready  = din_ready_r;
    assign din_chan   = chan_r;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign sat_flag   = sat_flag_r;

endmodule

// File: tb/tb_comb_reverb_mc.sv
// Self-checking bench for comb_reverb_mc (2 channels, 16-deep delay lines).
// A reference comb model predicts each output; predictions queue up when a
// sample is driven and are popped when the DUT presents dout_valid.
module tb_comb_reverb_mc;

    localparam int CH    = 2;
    localparam int W     = 16;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              enable = 1'b1;
    logic              bypass = 1'b0;
    logic [DL-1:0]     delay_len = '0;
    logic [15:0]       feedback_gain = '0, dry_gain = '0, wet_gain = '0;
    logic              sat_clear = 1'b0;
    logic              sat_flag;
    logic signed [W-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              din_ready;
    logic [0:0]        din_chan;
    logic signed [W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready = 1'b1;

    always #5 clk = ~clk;

    comb_reverb_mc #(.G_CHANNELS(CH), .G_DATA_WIDTH(W), .G_DELAY_DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bypass(bypass),
        .delay_len(delay_len), .feedback_gain(feedback_gain), .dry_gain(dry_gain),
        .wet_gain(wet_gain), .sat_clear(sat_clear), .sat_flag(sat_flag),
        .din(din), .din_valid(din_valid), .din_ready(din_ready), .din_chan(din_chan),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    int checks = 0;
    int errors = 0;

    int m_mem [CH][DEPTH];
    int m_ptr, m_chan;
    int exp_q [$];
    int cfg_dl, cfg_fb, cfg_dry, cfg_wet;

    function automatic longint mulq(input int g, input int v);
        longint p;
        p = longint'(g) * longint'(v);
        return p >>> 15;
    endfunction

    function automatic int clamp(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CH; c++)
            for (int p = 0; p < DEPTH; p++) m_mem[c][p] = 0;
        m_ptr  = 0;
        m_chan = 0;
        exp_q.delete();
    endtask

    task automatic model_push(input int x, input bit byp);
        int dl, d, y;
        dl = (cfg_dl == 0) ? 1 : cfg_dl;
        d  = m_mem[m_chan][(m_ptr - dl + DEPTH) % DEPTH];
        if (byp) begin
            y = x;
        end else begin
            m_mem[m_chan][m_ptr] = clamp(longint'(x) + mulq(cfg_fb, d));
            y = clamp(mulq(cfg_dry, x) + mulq(cfg_wet, d));
        end
        exp_q.push_back(y);
        if (m_chan == CH - 1) begin
            m_chan = 0;
            m_ptr  = (m_ptr + 1) % DEPTH;
        end else begin
            m_chan = m_chan + 1;
        end
    endtask

    task automatic set_cfg(input int dl, input int fb, input int dry, input int wet);
        cfg_dl = dl; cfg_fb = fb; cfg_dry = dry; cfg_wet = wet;
    endtask

    // Drive one sample, check latency and value; optionally stall dout_ready for hold cycles
    task automatic send(input int x, input bit byp, input int hold, output int y);
        int n, k, e;
        logic signed [W-1:0] held;
        n = 0;
        @(negedge clk);
        while (din_ready !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        checks++;
        if (din_ready !== 1'b1) begin
            errors++; $display("FAIL din_ready_wait: got %b expected 1", din_ready);
        end
        checks++;
        if (int'(din_chan) !== m_chan) begin
            errors++; $display("FAIL din_chan: got %0d expected %0d", din_chan, m_chan);
        end
        din = W'(x); din_valid = 1'b1; bypass = byp;
        delay_len = DL'(cfg_dl); feedback_gain = 16'(cfg_fb);
        dry_gain = 16'(cfg_dry); wet_gain = 16'(cfg_wet);
        dout_ready = (hold == 0);
        model_push(x, byp);
        @(posedge clk); #1;
        // scramble controls while the sample is in flight
        din_valid = 1'b0; din = W'($urandom); bypass = ~byp;
        delay_len = DL'($urandom); feedback_gain = 16'($urandom);
        dry_gain = 16'($urandom); wet_gain = 16'($urandom);
        k = 1;
        while (dout_valid !== 1'b1 && k < 10) begin @(posedge clk); #1; k++; end
        checks++;
        if (k !== 3) begin
            errors++; $display("FAIL latency: got %0d cycles expected 3", k);
        end
        e = exp_q.pop_front();
        y = int'(dout);
        checks++;
        if (y !== e) begin
            errors++; $display("FAIL scoreboard: got %0d expected %0d", y, e);
        end
        if (hold > 0) begin
            held = dout;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                checks++;
                if (dout_valid !== 1'b1 || dout !== held || din_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%b dout=%0d ready=%b expected 1/%0d/0",
                             dout_valid, dout, din_ready, held);
                end
            end
            dout_ready = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_release: got ready=%b valid=%b expected 1/0", din_ready, dout_valid);
            end
        end
    endtask

    task automatic wait_ready_count(input int expected, input string name);
        int n;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (din_ready !== 1'b1 && n < 100);
        checks++;
        if (n !== expected) begin
            errors++; $display("FAIL %s: got %0d cycles expected %0d", name, n, expected);
        end
    endtask

    task automatic restart_clear();
        @(negedge clk); enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (din_ready !== 1'b0 || dout_valid !== 1'b0 || din_chan !== 1'b0) begin
            errors++;
            $display("FAIL enable_low: got ready=%b valid=%b chan=%0d expected 0/0/0",
                     din_ready, dout_valid, din_chan);
        end
        @(negedge clk); enable = 1'b1;
        // one cycle to see the enable rise, then one clear write per word
        wait_ready_count(33, "enable_clear_len");
        model_clear();
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dout !== 16'sd0) begin errors++; $display("FAIL rst_dout: got %0d expected 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid: got %b expected 0", dout_valid); end
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL rst_din_ready: got %b expected 0", din_ready); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL rst_sat_flag: got %b expected 0", sat_flag); end
        checks++; if (din_chan !== 1'b0) begin errors++; $display("FAIL rst_din_chan: got %0d expected 0", din_chan); end
        @(negedge clk); reset_n = 1'b1;
        wait_ready_count(32, "clear_len");
        model_clear();
    endtask

    task automatic test_impulse();
        int exp0 [10] = '{1000, 0, 0, 1000, 0, 0, 500, 0, 0, 250};
        int y0, y1;
        set_cfg(3, 16'h4000, 16'h8000, 16'h8000);
        for (int i = 0; i < 10; i++) begin
            send((i == 0) ? 1000 : 0, 1'b0, 0, y0);
            send(0, 1'b0, 0, y1);
            checks++;
            if (y0 !== exp0[i]) begin errors++; $display("FAIL impulse_ch0[%0d]: got %0d expected %0d", i, y0, exp0[i]); end
            checks++;
            if (y1 !== 0) begin errors++; $display("FAIL impulse_ch1[%0d]: got %0d expected 0", i, y1); end
        end
    endtask

    task automatic test_backpressure();
        int y;
        set_cfg(2, 16'h2000, 16'h6000, 16'h3000);
        send(777, 1'b0, 10, y);
    endtask

    task automatic test_saturation();
        int y;
        restart_clear();
        set_cfg(1, 16'h8000, 16'h8000, 16'h8000);
        send(30000, 1'b0, 0, y);
        checks++; if (y !== 30000) begin errors++; $display("FAIL sat_first: got %0d expected 30000", y); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_early: got %b expected 0", sat_flag); end
        send(0, 1'b0, 0, y);
        send(30000, 1'b0, 0, y);
        checks++; if (y !== 32767) begin errors++; $display("FAIL sat_second: got %0d expected 32767", y); end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b expected 1", sat_flag); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_sticky: got %b expected 1", sat_flag); end
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_clear: got %b expected 0", sat_flag); end
        send(0, 1'b0, 0, y);
        sat_clear = 1'b1;
        send(30000, 1'b0, 0, y);
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_wins_clear: got %b expected 1", sat_flag); end
        @(posedge clk); #1;
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clear_after: got %b expected 0", sat_flag); end
        sat_clear = 1'b0;
        // odd number of samples sent: channel counter sits at 1 before the next restart
    endtask

    task automatic test_delay_zero();
        int exp_y [4] = '{0, 0, 100, 200};
        int xin [4] = '{100, 200, 300, 400};
        int y;
        restart_clear();
        set_cfg(0, 16'h0000, 16'h0000, 16'h8000);
        for (int i = 0; i < 4; i++) begin
            send(xin[i], 1'b0, 0, y);
            checks++;
            if (y !== exp_y[i]) begin errors++; $display("FAIL delay_zero[%0d]: got %0d expected %0d", i, y, exp_y[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        @(negedge clk);
        while (din_ready !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        din = 16'sd500; din_valid = 1'b1; bypass = 1'b0;
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got valid=%b ready=%b expected 0/0", dout_valid, din_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_hold: got %b expected 0", dout_valid); end
        @(negedge clk); reset_n = 1'b1;
        wait_ready_count(32, "reclear_len");
        model_clear();
        test_impulse();
    endtask

    task automatic test_bypass();
        int y;
        restart_clear();
        set_cfg(3, 16'h7FFF, 16'h0000, 16'h0000);
        send(-1234, 1'b1, 0, y);
        checks++; if (y !== -1234) begin errors++; $display("FAIL bypass_out: got %0d expected -1234", y); end
        send(0, 1'b1, 0, y);
        test_impulse();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_cfg(0, 0, 0, 0);
        model_clear();
        test_reset();
        test_impulse();
        test_backpressure();
        test_saturation();
        test_delay_zero();
        test_reset_mid();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
